seq_generator: RTL



---
 rtl/seq_generator.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/seq_generator.sv
// seq_generator: serial pattern transmitter.
// Captures a WIDTH-bit pattern on an accepted start and shifts it out MSB-first,
// one bit per clock, for a programmable number of back-to-back repetitions.
// Optional feature macro: PARITY_EN appends an even-parity bit after each repetition.
// All outputs come straight from flops; nothing combinational reaches x/valid/busy/done.
module seq_generator #(
   parameter int WIDTH = 4,
   parameter int REP_W = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [WIDTH-1:0] pattern,
   input  logic [REP_W-1:0] repeat_cnt,
   output logic             x,
   output logic             valid,
   output logic             busy,
   output logic             done
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
`ifdef PARITY_EN
      PARITY,
`endif
      DONE
   } state_t;

   state_t state, state_d;

   logic [WIDTH-1:0] hold, hold_d;
   logic [WIDTH-1:0] shreg, shreg_d;
   logic [CNT_W-1:0] bitcnt, bitcnt_d;
   logic [REP_W-1:0] rep, rep_d;
   logic             x_d, valid_d, busy_d, done_d;
   logic             end_of_rep;

   // Next-state and datapath decisions, followed by the output values the
   // next state will present so that every output can be registered.
   always_comb begin
      state_d    = state;
      hold_d     = hold;
      shreg_d    = shreg;
      bitcnt_d   = bitcnt;
      rep_d      = rep;
      end_of_rep = 1'b0;

      case (state)
         IDLE: begin
            if (start) begin
               hold_d   = pattern;
               shreg_d  = pattern;
               rep_d    = (repeat_cnt == '0) ? REP_W'(1) : repeat_cnt;
               bitcnt_d = '0;
               state_d  = SHIFT;
            end
         end
         SHIFT: begin
            if (bitcnt == LAST_BIT) begin
`ifdef PARITY_EN
               state_d = PARITY;
`else
               end_of_rep = 1'b1;
`endif
            end else begin
               shreg_d  = {shreg[WIDTH-2:0], 1'b0};
               bitcnt_d = bitcnt + CNT_W'(1);
            end
         end
`ifdef PARITY_EN
         PARITY: begin
            end_of_rep = 1'b1;
         end
`endif
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // A finished repetition either restarts from the held copy with no gap
      // or, on the last repetition, closes the stream.
      if (end_of_rep) begin
         if (rep > REP_W'(1)) begin
            shreg_d  = hold;
            rep_d    = rep - REP_W'(1);
            bitcnt_d = '0;
            state_d  = SHIFT;
         end else begin
            state_d = DONE;
         end
      end

      x_d     = 1'b0;
      valid_d = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      case (state_d)
         SHIFT: begin
            x_d     = shreg_d[WIDTH-1];
            valid_d = 1'b1;
            busy_d  = 1'b1;
         end
`ifdef PARITY_EN
         PARITY: begin
            x_d     = ^hold_d;
            valid_d = 1'b1;
            busy_d  = 1'b1;
         end
`endif
         DONE: begin
            done_d = 1'b1;
         end
         default: begin
            x_d = 1'b0;
         end
      endcase
   end

   // State, datapath and output registers; reset abandons any stream in flight.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= IDLE;
         hold   <= '0;
         shreg  <= '0;
         bitcnt <= '0;
         rep    <= '0;
         x      <= 1'b0;
         valid  <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         state  <= state_d;
         hold   <= hold_d;
         shreg  <= shreg_d;
         bitcnt <= bitcnt_d;
         rep    <= rep_d;
         x      <= x_d;
         valid  <= valid_d;
         busy   <= busy_d;
         done   <= done_d;
      end
   end

endmodule
